min_unpool: RTL and testbench

Streaming min-unpool block: the inverse end of the 3x3/stride-1 min-pooling stage. It accepts a 6x6 pooled map in raster order, one value per beat, each tagged with its argmin window offset. It scatters every value back to its source position in an 8x8 buffer, keeping the minimum on overlapping windows. Once the frame is complete, it streams the reconstructed 8x8 map out in raster order to the downstream decoder/upsampling stage.

---
 rtl/minpool_pkg.sv | 35 +++
 rtl/min_unpool_buf.sv | 35 +++
 rtl/min_unpool.sv | 170 +++++++++++++++++
 tb/tb_min_unpool.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/minpool_pkg.sv
// Shared constants for the 3x3/stride-1 min-pool / min-unpool pair.
package minpool_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned IN_DIM  = 6;
  localparam int unsigned WIN     = 3;
  localparam int unsigned OUT_DIM = IN_DIM + WIN - 1;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned ADDR_W  = 2 * CNT_W;
  localparam int unsigned NCELL   = OUT_DIM * OUT_DIM;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned COLL_W  = 6;

  localparam logic [DATA_W-1:0] FILL = 8'hFF;

  // FSM state encoding
  localparam logic [0:0] ST_ACCEPT = 1'b0;
  localparam logic [0:0] ST_EMIT   = 1'b1;

  // argmin index fields: [3:2] row offset, [1:0] col offset
  localparam int unsigned IDX_FLD_W  = 2;
  localparam int unsigned IDX_DR_LSB = 2;
  localparam int unsigned IDX_DC_LSB = 0;
  localparam logic [IDX_FLD_W-1:0] IDX_BAD = 2'd3;

  localparam logic [CNT_W-1:0] IN_LAST  = CNT_W'(IN_DIM - 1);
  localparam logic [CNT_W-1:0] OUT_LAST = CNT_W'(OUT_DIM - 1);

  // Flat buffer address of (row, col) in the output grid.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [CNT_W-1:0] row,
                                                  input logic [CNT_W-1:0] col);
    return {row, col};
  endfunction

endpackage

// File: rtl/min_unpool_buf.sv
// 8x8 reconstruction buffer: min-write port plus read-and-clear port.
module min_unpool_buf
  import minpool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_wr_en,
  input  logic [ADDR_W-1:0] i_rd_addr,
  input  logic              i_clr_en,
  output logic [DATA_W-1:0] o_rd_data
);

  logic [DATA_W-1:0] r_cell [NCELL];

  // Cells keep the running minimum; a read handshake restores FILL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NCELL); i++) begin
        r_cell[i] <= FILL;
      end
    end else begin
      if (i_wr_en && (i_wr_data < r_cell[i_wr_addr])) begin
        r_cell[i_wr_addr] <= i_wr_data;
      end
      if (i_clr_en) begin
        r_cell[i_rd_addr] <= FILL;
      end
    end
  end

  assign o_rd_data = r_cell[i_rd_addr];

endmodule

// File: rtl/min_unpool.sv
// Streaming min-unpool: scatters a 6x6 pooled frame into an 8x8 buffer
// (min on overlap), then streams the 8x8 map out in raster order.
// Optional collision counter enabled by MIN_UNPOOL_COLLISION_CNT_EN.
module min_unpool
  import minpool_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  out_row,
  output logic [CNT_W-1:0]  out_col,
  output logic              out_last,
`ifdef MIN_UNPOOL_COLLISION_CNT_EN
  output logic [COLL_W-1:0] coll_cnt,
`endif
  output logic              err_idx
);

  logic [0:0]           r_state;
  logic [0:0]           w_state_nxt;
  logic [CNT_W-1:0]     r_in_row;
  logic [CNT_W-1:0]     r_in_col;
  logic [CNT_W-1:0]     r_out_row;
  logic [CNT_W-1:0]     r_out_col;
  logic                 r_err;

  logic                 w_in_hs;
  logic                 w_out_hs;
  logic [IDX_FLD_W-1:0] w_dr;
  logic [IDX_FLD_W-1:0] w_dc;
  logic                 w_idx_ok;
  logic [ADDR_W-1:0]    w_wr_addr;
  logic [ADDR_W-1:0]    w_rd_addr;
  logic [DATA_W-1:0]    w_rd_data;
  logic                 w_in_end;
  logic                 w_out_end;

  assign w_dr      = in_idx[IDX_DR_LSB +: IDX_FLD_W];
  assign w_dc      = in_idx[IDX_DC_LSB +: IDX_FLD_W];
  assign w_idx_ok  = (w_dr != IDX_BAD) && (w_dc != IDX_BAD);
  assign w_wr_addr = cell_addr(r_in_row + CNT_W'(w_dr), r_in_col + CNT_W'(w_dc));
  assign w_rd_addr = cell_addr(r_out_row, r_out_col);
  assign w_in_end  = (r_in_row == IN_LAST) && (r_in_col == IN_LAST);
  assign w_out_end = (r_out_row == OUT_LAST) && (r_out_col == OUT_LAST);
  assign w_in_hs   = in_valid && in_ready;
  assign w_out_hs  = out_valid && out_ready;

  min_unpool_buf u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_addr (w_wr_addr),
    .i_wr_data (in_data),
    .i_wr_en   (w_in_hs && w_idx_ok),
    .i_rd_addr (w_rd_addr),
    .i_clr_en  (w_out_hs),
    .o_rd_data (w_rd_data)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake decode from the state register
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      ST_ACCEPT: begin
        in_ready = 1'b1;
        if (in_valid && w_in_end) begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        out_valid = 1'b1;
        if (out_ready && w_out_end) begin
          w_state_nxt = ST_ACCEPT;
        end
      end
      default: w_state_nxt = ST_ACCEPT;
    endcase
  end

  // Pooled-input raster counter; wraps to (0,0) after the last beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_in_row <= '0;
      r_in_col <= '0;
    end else if (w_in_hs) begin
      if (r_in_col == IN_LAST) begin
        r_in_col <= '0;
        r_in_row <= (r_in_row == IN_LAST) ? '0 : r_in_row + CNT_W'(1);
      end else begin
        r_in_col <= r_in_col + CNT_W'(1);
      end
    end
  end

  // Output raster counter; natural 3-bit wrap returns it to (0,0)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_row <= '0;
      r_out_col <= '0;
    end else if (w_out_hs) begin
      r_out_col <= r_out_col + CNT_W'(1);
      if (r_out_col == OUT_LAST) begin
        r_out_row <= r_out_row + CNT_W'(1);
      end
    end
  end

  // Sticky flag for a consumed beat carrying an out-of-window offset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else if (w_in_hs && !w_idx_ok) begin
      r_err <= 1'b1;
    end
  end

  assign out_data = w_rd_data;
  assign out_row  = r_out_row;
  assign out_col  = r_out_col;
  assign out_last = w_out_end;
  assign err_idx  = r_err;

`ifdef MIN_UNPOOL_COLLISION_CNT_EN
  logic [NCELL-1:0]  r_written;
  logic [COLL_W-1:0] r_coll_cnt;
  logic              w_first;

  assign w_first = (r_in_row == '0) && (r_in_col == '0);

  // Per-frame written bitmap; counts valid beats landing on a written cell
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_written  <= '0;
      r_coll_cnt <= '0;
    end else if (w_in_hs) begin
      if (w_first) begin
        r_written  <= '0;
        r_coll_cnt <= '0;
        if (w_idx_ok) begin
          r_written[w_wr_addr] <= 1'b1;
        end
      end else if (w_idx_ok) begin
        r_written[w_wr_addr] <= 1'b1;
        if (r_written[w_wr_addr]) begin
          r_coll_cnt <= r_coll_cnt + COLL_W'(1);
        end
      end
    end
  end

  assign coll_cnt = r_coll_cnt;
`endif

endmodule

// File: tb/tb_min_unpool.sv
// Self-checking bench for min_unpool: table of frame scenarios with a
// reference scatter-min model feeding a pixel scoreboard.
module tb_min_unpool;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [3:0] in_idx;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic [2:0] out_row;
  logic [2:0] out_col;
  logic       out_last;
  logic       err_idx;
`ifdef MIN_UNPOOL_COLLISION_CNT_EN
  logic [5:0] coll_cnt;
`endif

  min_unpool dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_idx    (in_idx),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_col   (out_col),
    .out_last  (out_last),
`ifdef MIN_UNPOOL_COLLISION_CNT_EN
    .coll_cnt  (coll_cnt),
`endif
    .err_idx   (err_idx)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] data;
    logic       last;
  } pix_t;

  typedef struct {
    int         pat;
    bit         tog;
    bit         chk;
    logic [2:0] row;
    logic [2:0] col;
    logic [7:0] val;
  } vec_t;

  pix_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic [7:0] mdata [36];
  logic [3:0] midx  [36];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Stimulus patterns: 0 ramp, 1 diagonal shift, 2 overlap, 3 bad idx, 4 random
  task automatic build_pattern(input int pat);
    for (int n = 0; n < 36; n++) begin
      case (pat)
        0: begin mdata[n] = 8'h10 + 8'(n); midx[n] = 4'b0000; end
        1: begin mdata[n] = (n == 0) ? 8'h20 : 8'h40; midx[n] = 4'b0101; end
        2: begin
          mdata[n] = (n == 0) ? 8'h30 : (n == 7) ? 8'h50 : 8'h60;
          midx[n]  = (n == 0) ? 4'b0101 : 4'b0000;
        end
        3: begin mdata[n] = 8'h10 + 8'(n); midx[n] = (n == 7) ? 4'b1100 : 4'b0000; end
        default: begin
          mdata[n] = 8'($urandom_range(0, 255));
          midx[n]  = {2'($urandom_range(0, 2)), 2'($urandom_range(0, 2))};
        end
      endcase
    end
  endtask

  task automatic run_frame(input int pat, input bit tog, input logic [2:0] sr,
                           input logic [2:0] sc, output logic [7:0] spot);
    logic [7:0] model [64];
    int r, c, dr, dc, got, cyc;
    pix_t e;
    spot = 8'hxx;
    build_pattern(pat);
    for (int i = 0; i < 64; i++) model[i] = 8'hFF;
    for (int n = 0; n < 36; n++) begin
      in_valid = 1'b1;
      in_data  = mdata[n];
      in_idx   = midx[n];
      @(negedge clk);
      check("in_ready_accept", 32'(in_ready), 32'd1);
      if (n == 35) check("out_valid_before_last", 32'(out_valid), 32'd0);
      if (pat == 3 && n == 7) check("err_before_bad", 32'(err_idx), 32'd0);
      @(posedge clk); #1;
      r = n / 6; c = n % 6; dr = int'(midx[n][3:2]); dc = int'(midx[n][1:0]);
      if (dr != 3 && dc != 3 && mdata[n] < model[(r + dr) * 8 + c + dc])
        model[(r + dr) * 8 + c + dc] = mdata[n];
      if (pat == 3 && n == 7) check("err_after_bad", 32'(err_idx), 32'd1);
    end
    // hold in_valid during EMIT on toggled frames; it must be ignored
    in_valid = tog;
    in_data  = 8'h00;
    in_idx   = 4'b0000;
    check("latency_out_valid", {30'd0, out_valid, in_ready}, 32'b10);
    for (int i = 0; i < 64; i++) begin
      e.row = 3'(i / 8); e.col = 3'(i % 8); e.data = model[i]; e.last = (i == 63);
      exp_q.push_back(e);
    end
    got = 0; cyc = 0;
    while (got < 64 && cyc < 400) begin
      out_ready = tog ? (cyc % 2 == 0) : 1'b1;
      @(negedge clk);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check($sformatf("pixel_%0d_%0d", e.row, e.col),
              32'({out_row, out_col, out_data, out_last}), 32'(e));
        if (out_row == sr && out_col == sc) spot = out_data;
        got++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    if (got < 64) check("emit_timeout", 32'(got), 32'd64);
    check("back_to_accept", {30'd0, out_valid, in_ready}, 32'b01);
  endtask

  vec_t       tab [8];
  logic [7:0] spot;

  initial begin
    tab[0] = '{0, 1'b0, 1'b1, 3'd3, 3'd4, 8'h26};
    tab[1] = '{0, 1'b1, 1'b1, 3'd6, 3'd2, 8'hFF};
    tab[2] = '{1, 1'b0, 1'b1, 3'd1, 3'd1, 8'h20};
    tab[3] = '{1, 1'b0, 1'b1, 3'd0, 3'd3, 8'hFF};
    tab[4] = '{1, 1'b1, 1'b1, 3'd2, 3'd2, 8'h40};
    tab[5] = '{2, 1'b0, 1'b1, 3'd1, 3'd1, 8'h30};
    tab[6] = '{3, 1'b0, 1'b1, 3'd1, 3'd1, 8'hFF};
    tab[7] = '{4, 1'b1, 1'b0, 3'd0, 3'd0, 8'h00};

    rst_n = 1'b0; in_valid = 1'b0; in_data = 8'h00; in_idx = 4'h0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_handshake", {30'd0, out_valid, in_ready}, 32'b01);
    check("reset_out", 32'({out_row, out_col, out_data, out_last, err_idx}),
          32'({3'd0, 3'd0, 8'hFF, 1'b0, 1'b0}));
`ifdef MIN_UNPOOL_COLLISION_CNT_EN
    check("reset_coll_cnt", 32'(coll_cnt), 32'd0);
`endif
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_frame(tab[i].pat, tab[i].tog, tab[i].row, tab[i].col, spot);
      if (tab[i].chk) check($sformatf("spot_vec%0d", i), 32'(spot), 32'(tab[i].val));
`ifdef MIN_UNPOOL_COLLISION_CNT_EN
      if (tab[i].pat == 2) check("coll_cnt_overlap", 32'(coll_cnt), 32'd1);
      if (tab[i].pat == 0) check("coll_cnt_ramp", 32'(coll_cnt), 32'd0);
`endif
    end
    check("err_sticky", 32'(err_idx), 32'd1);

    // abort a partial frame with a reset; aborted writes must not survive
    for (int n = 0; n < 20; n++) begin
      in_valid = 1'b1; in_data = 8'h00; in_idx = 4'b1010;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_handshake", {30'd0, out_valid, in_ready}, 32'b01);
    check("abort_out", 32'({out_data, err_idx}), 32'({8'hFF, 1'b0}));
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_frame(0, 1'b0, 3'd2, 3'd2, spot);
    check("after_abort_spot", 32'(spot), 32'h1E);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
